pc_next_stage: RTL and testbench
================================

PC_NEXT_STAGE -- requirements
Module: pc_next_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imm_shifted, input, 32, the sign-extended branch immediate already shifted left by 2, taken from the shift-left-2 stage.
REQ-005 SHALL have port branch_taken, input, 1, a resolved conditional-branch redirect request.
REQ-006 SHALL have port jump, input, 1, an unconditional J-type redirect request.
REQ-007 SHALL have port jump_index, input, 26, the J-type instruction index field.
REQ-008 SHALL have port fetch_ready, input, 1, asserted when instruction fetch accepts the current pc.
REQ-009 SHALL have port pc, output, 32, the current program counter.
REQ-010 SHALL have port pc_valid, output, 1, asserted when pc is presentable to fetch.
REQ-011 SHALL have port redirect_pending, output, 1, asserted when a captured redirect awaits fetch_ready.

Function
REQ-012 SHALL compute pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-013 SHALL compute branch_target = pc_plus4 + imm_shifted, modulo 2^32, with no overflow flag.
REQ-014 SHALL compute jump_target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-015 SHALL resolve next-PC priority as jump > branch_taken > sequential; when jump and branch_taken are both high, jump wins.
REQ-016 SHALL implement two states: RUN and HOLD.
REQ-017 In RUN with pc_valid=1 and fetch_ready=1, SHALL load pc on the next edge with the selected target, giving 1-cycle latency.
REQ-018 In RUN with fetch_ready=0 and jump or branch_taken high, SHALL capture the selected target into a held-target register, keep pc unchanged, and move to HOLD.
REQ-019 In RUN with fetch_ready=0 and no redirect, SHALL keep pc unchanged and stay in RUN.
REQ-020 In HOLD with fetch_ready=1, SHALL load pc with the held target, return to RUN, and ignore same-cycle redirect inputs.
REQ-021 In HOLD with fetch_ready=0 and a new redirect, SHALL overwrite the held target with the newer target, recomputed from the current pc.
REQ-022 SHALL drive redirect_pending high exactly while in HOLD.
REQ-023 SHALL keep pc_valid low until the first rising edge after reset deassertion, then high permanently; while pc_valid=0, pc SHALL NOT advance.

Reset
REQ-024 On reset assertion, SHALL immediately set pc=RESET_PC, pc_valid=0, state=RUN, redirect_pending=0, held target=0, independent of clk.
REQ-025 Reset mid-HOLD SHALL discard the held target; no redirect SHALL survive reset.

Structure
REQ-026 SHALL take the 32-bit data width, RUN/HOLD state encoding, and PC step constant 4 from shared package mips_pkg.
REQ-027 SHALL instantiate one sub-module, adder32, twice: once for pc_plus4 and once for branch_target.

Verification
REQ-028 Reset, then fetch_ready=1 for 3 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; pc_valid=1 from the first edge.
REQ-029 pc=0x100, imm_shifted=0xFFFF_FFF0, branch_taken=1, fetch_ready=1 -> next pc=0x0F4.
REQ-030 pc=0x1000_0000, jump=1, jump_index=26'h000_0040, branch_taken=1 -> next pc=0x1000_0100, confirming jump priority.
REQ-031 fetch_ready=0, branch to 0x200 captured -> redirect_pending=1 and pc held; fetch_ready=1 -> pc=0x200 and redirect_pending=0 next edge.
REQ-032 pc=0xFFFF_FFFC sequential -> pc=0x0; reset asserted mid-HOLD between clk edges -> pc=RESET_PC and redirect_pending=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mips_pkg
// Description : Shared datapath width, PC step and next-PC state encoding.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int                 c_data_w  = 32;
   localparam logic [c_data_w-1:0] c_pc_step = 32'd4;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } pc_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_stage_adder32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : adder32
// Description : Plain modulo-2^32 adder; carry out is intentionally dropped.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module adder32
   import mips_pkg::*;
(
   input  logic [c_data_w-1:0] a,
   input  logic [c_data_w-1:0] b,
   output logic [c_data_w-1:0] sum
);

   assign sum = a + b;

endmodule : adder32
`default_nettype wire

// File: rtl/pc_next_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : pc_next_stage
// Description : Program counter with jump/branch redirect and fetch back-pressure.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_next_stage
   import mips_pkg::*;
#(
   parameter logic [c_data_w-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [c_data_w-1:0] imm_shifted,
   input  logic                branch_taken,
   input  logic                jump,
   input  logic [25:0]         jump_index,
   input  logic                fetch_ready,
   output logic [c_data_w-1:0] pc,
   output logic                pc_valid,
   output logic                redirect_pending
);

   logic [c_data_w-1:0] r_pc;
   logic                r_pc_valid;
   logic                r_redirect_pending;
   logic [c_data_w-1:0] r_held_target;
   pc_state_t           r_state;

   logic [c_data_w-1:0] w_pc_plus4;
   logic [c_data_w-1:0] w_branch_target;
   logic [c_data_w-1:0] w_jump_target;
   logic [c_data_w-1:0] w_sel_target;
   logic                w_redirect;

   adder32 u_add_plus4 (
      .a   (r_pc),
      .b   (c_pc_step),
      .sum (w_pc_plus4)
   );

   adder32 u_add_branch (
      .a   (w_pc_plus4),
      .b   (imm_shifted),
      .sum (w_branch_target)
   );

   assign w_jump_target = {w_pc_plus4[31:28], jump_index, 2'b00};
   assign w_redirect    = jump | branch_taken;

   // Jump outranks a simultaneously resolved branch.
   always_comb begin
      w_sel_target = w_pc_plus4;
      if (jump)
         w_sel_target = w_jump_target;
      else if (branch_taken)
         w_sel_target = w_branch_target;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc               <= RESET_PC;
         r_pc_valid         <= 1'b0;
         r_redirect_pending <= 1'b0;
         r_held_target      <= '0;
         r_state            <= ST_RUN;
      end else begin
         r_pc_valid <= 1'b1;
         case (r_state)
            ST_RUN: begin
               if (r_pc_valid && fetch_ready) begin
                  r_pc <= w_sel_target;
               end else if (r_pc_valid && w_redirect) begin
                  r_held_target      <= w_sel_target;
                  r_redirect_pending <= 1'b1;
                  r_state            <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Redirects arriving in the release cycle are dropped.
               if (fetch_ready) begin
                  r_pc               <= r_held_target;
                  r_redirect_pending <= 1'b0;
                  r_state            <= ST_RUN;
               end else if (w_redirect) begin
                  r_held_target <= w_sel_target;
               end
            end
            default: begin
               r_redirect_pending <= 1'b0;
               r_state            <= ST_RUN;
            end
         endcase
      end
   end

   assign pc               = r_pc;
   assign pc_valid         = r_pc_valid;
   assign redirect_pending = r_redirect_pending;

endmodule : pc_next_stage
`default_nettype wire

// File: tb/tb_pc_next_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_pc_next_stage
// Description : Directed self-checking bench for pc_next_stage.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pc_next_stage;

   logic        clk;
   logic        reset;
   logic [31:0] imm_shifted;
   logic        branch_taken;
   logic        jump;
   logic [25:0] jump_index;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        pc_valid;
   logic        redirect_pending;

   int n_checks;
   int n_fail;

   pc_next_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .reset            (reset),
      .imm_shifted      (imm_shifted),
      .branch_taken     (branch_taken),
      .jump             (jump),
      .jump_index       (jump_index),
      .fetch_ready      (fetch_ready),
      .pc               (pc),
      .pc_valid         (pc_valid),
      .redirect_pending (redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fr, input logic j, input logic [25:0] ji,
                        input logic bt, input logic [31:0] imm);
      fetch_ready  = fr;
      jump         = j;
      jump_index   = ji;
      branch_taken = bt;
      imm_shifted  = imm;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
      #2;
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'h0);
      check("rst_pending", {31'b0, redirect_pending}, 32'h0);
      reset = 1'b0;
      #1;
      check("pre_edge_valid", {31'b0, pc_valid}, 32'h0);

      // First edge only raises pc_valid; then sequential stepping.
      tick();
      check("seq0_pc", pc, 32'h0);
      check("seq0_valid", {31'b0, pc_valid}, 32'h1);
      tick();
      check("seq1_pc", pc, 32'h4);
      tick();
      check("seq2_pc", pc, 32'h8);
      tick();
      check("seq3_pc", pc, 32'hC);

      // Jump to 0x100, then backward branch.
      drive(1'b1, 1'b1, 26'h40, 1'b0, 32'h0);
      tick();
      check("jump_100", pc, 32'h100);
      drive(1'b1, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFF0);
      tick();
      check("branch_back", pc, 32'h0F4);
      drive(1'b1, 1'b0, 26'h0, 1'b1, 32'h0FFF_FF08);
      tick();
      check("branch_fwd", pc, 32'h1000_0000);

      // Jump and branch together: jump wins.
      drive(1'b1, 1'b1, 26'h40, 1'b1, 32'h0000_0040);
      tick();
      check("jump_prio", pc, 32'h1000_0100);

      // Stalled fetch without redirect holds pc in RUN.
      drive(1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
      tick();
      check("stall_pc", pc, 32'h1000_0100);
      check("stall_pending", {31'b0, redirect_pending}, 32'h0);

      // Capture jump, overwrite with branch to 0x200, release ignoring new jump.
      drive(1'b0, 1'b1, 26'h80, 1'b0, 32'h0);
      tick();
      check("hold_pc", pc, 32'h1000_0100);
      check("hold_pending", {31'b0, redirect_pending}, 32'h1);
      drive(1'b0, 1'b0, 26'h0, 1'b1, 32'hF000_00FC);
      tick();
      check("hold2_pc", pc, 32'h1000_0100);
      check("hold2_pending", {31'b0, redirect_pending}, 32'h1);
      drive(1'b1, 1'b1, 26'h3, 1'b0, 32'h0);
      tick();
      check("release_pc", pc, 32'h200);
      check("release_pending", {31'b0, redirect_pending}, 32'h0);

      // Top-of-memory wrap.
      drive(1'b1, 1'b0, 26'h0, 1'b1, 32'hFFFF_FDF8);
      tick();
      check("to_top", pc, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
      tick();
      check("wrap_pc", pc, 32'h0);
      tick();
      check("after_wrap", pc, 32'h4);

      // Enter HOLD, then reset asynchronously between edges.
      drive(1'b0, 1'b0, 26'h0, 1'b1, 32'h100);
      tick();
      check("hold3_pending", {31'b0, redirect_pending}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("async_pc", pc, 32'h0);
      check("async_pending", {31'b0, redirect_pending}, 32'h0);
      check("async_valid", {31'b0, pc_valid}, 32'h0);
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
      tick();
      check("post_rst_pc", pc, 32'h0);
      check("post_rst_valid", {31'b0, pc_valid}, 32'h1);
      tick();
      check("no_stale_redirect", pc, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_next_stage
`default_nettype wire
